// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA/writer RAM arbiter and related arbiters.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DISP  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // 640x480 @ 60 Hz timing
  localparam int unsigned VGA_H_TOTAL = 800;
  localparam int unsigned VGA_HD      = 640;
  localparam int unsigned VGA_VD      = 480;
  localparam int unsigned VGA_V_TOTAL = 525;

  // Width of a round-robin index for n requesters (at least 1 bit)
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_pick
  import vga_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = rr_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] j;

  // Scan from ptr upwards, first hit wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: VGA display fetch has absolute priority while
// video_on=1; NUM_REQ writers are served round-robin during blanking,
// outside a GUARD window at the end of each line.
// Optional: define VGA_ARB_STARVE_DET_EN for per-writer starvation flags.
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned AW      = 15,
  parameter int unsigned DW      = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned H_TOTAL = VGA_H_TOTAL,
  parameter int unsigned GUARD   = 4,
  parameter int unsigned RD_LAT  = 1
`ifdef VGA_ARB_STARVE_DET_EN
  ,
  parameter int unsigned STARVE_MAX = 2048
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  video_on,
  input  logic [11:0]           pixel_x,
  input  logic [AW-1:0]         disp_addr,
  output logic [DW-1:0]         disp_rdata,
  output logic                  disp_rvalid,
  input  logic [NUM_REQ-1:0]    wr_req,
  input  logic [NUM_REQ*AW-1:0] wr_addr,
  input  logic [NUM_REQ*DW-1:0] wr_data,
  output logic [NUM_REQ-1:0]    wr_gnt,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_we,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
`ifdef VGA_ARB_STARVE_DET_EN
  ,
  output logic [NUM_REQ-1:0]    starve_flag
`endif
);

  localparam int unsigned IW = rr_idx_w(NUM_REQ);
  localparam int unsigned VP = 1 + RD_LAT;

  state_t               state;
  logic [IW-1:0]        rr;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 wr_ok;
  logic                 grant_en;
  logic [VP-1:0]        vpipe;
  logic [AW-1:0]        waddr [NUM_REQ];
  logic [DW-1:0]        wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign waddr[g] = wr_addr[g*AW +: AW];
    assign wdata[g] = wr_data[g*DW +: DW];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (wr_req),
    .ptr   (rr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign wr_ok    = !video_on && (pixel_x < 12'(H_TOTAL - GUARD));
  assign grant_en = !rst && (state == S_WRITE) && wr_ok && pick_found;
  assign wr_gnt   = grant_en ? pick_gnt : '0;

  // Arbitration FSM and registered RAM port
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr        <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (video_on) begin
      // display overrides every state, so S_DISP entry/stay is handled here
      state    <= S_DISP;
      mem_addr <= disp_addr;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        // S_DISP leaves on the first blank cycle using the idle rules
        S_IDLE, S_DISP: state <= (wr_ok && pick_found) ? S_WRITE : S_IDLE;
        S_WRITE: begin
          if (grant_en) begin
            mem_addr  <= waddr[pick_idx];
            mem_wdata <= wdata[pick_idx];
            mem_we    <= 1'b1;
            rr        <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-valid tracks video_on through the address register and RAM latency
  always_ff @(posedge clk) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[VP-2:0], video_on};
  end

  assign disp_rvalid = vpipe[VP-1];
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;

`ifdef VGA_ARB_STARVE_DET_EN
  logic [11:0] wait_cnt [NUM_REQ];

  // Per-writer wait counters with sticky starvation flags
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        wait_cnt[i]    <= '0;
        starve_flag[i] <= 1'b0;
      end else begin
        if (wr_req[i] && !wr_gnt[i])
          wait_cnt[i] <= (wait_cnt[i] == '1) ? wait_cnt[i] : wait_cnt[i] + 12'd1;
        else
          wait_cnt[i] <= '0;
        if (32'(wait_cnt[i]) >= STARVE_MAX) starve_flag[i] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter with a behavioural reference model.
module tb_vga_mem_arbiter;
  import vga_arb_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned HT = 800;
  localparam int unsigned G  = 4;
  localparam int unsigned RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             video_on;
  logic [11:0]      pixel_x;
  logic [AW-1:0]    disp_addr;
  logic [DW-1:0]    disp_rdata;
  logic             disp_rvalid;
  logic [N-1:0]     wr_req;
  logic [N*AW-1:0]  wr_addr;
  logic [N*DW-1:0]  wr_data;
  logic [N-1:0]     wr_gnt;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
`ifdef VGA_ARB_STARVE_DET_EN
  logic [N-1:0]     starve_flag;
`endif

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .NUM_REQ(N), .H_TOTAL(HT), .GUARD(G), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .video_on(video_on), .pixel_x(pixel_x),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VGA_ARB_STARVE_DET_EN
    , .starve_flag(starve_flag)
`endif
  );

  // RAM attached to the DUT (1-cycle read, read-before-write)
  logic [DW-1:0] ram  [2**AW];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A write may be granted in a cycle only if the write condition held in
  // the previous cycle as well; the winner is the first requester from rr.
  logic [DW-1:0] gold [2**AW];
  int unsigned   m_rr    = 0;
  bit            m_prev  = 1'b0;
  bit            m_we    = 1'b0;
  bit            m_known = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd    = '0;
  logic [DW-1:0] m_rdn;
  bit   [1:0]    m_vp    = '0;
  int            mw;

  function automatic bit cond_now();
    return !rst && !video_on && (int'(pixel_x) < int'(HT - G)) && (wr_req != '0);
  endfunction

  function automatic int winner();
    if (!(m_prev && cond_now())) return -1;
    for (int k = 0; k < int'(N); k++)
      if (wr_req[(int'(m_rr) + k) % int'(N)]) return (int'(m_rr) + k) % int'(N);
    return -1;
  endfunction

  always @(posedge clk) begin
    mw    = winner();
    m_rdn = gold[m_addr];
    if (m_we) gold[m_addr] = m_wdata;
    m_rd = m_rdn;
    if (rst) m_vp = '0;
    else     m_vp = {m_vp[0], video_on};
    if (rst) begin
      m_we = 0; m_addr = '0; m_wdata = '0; m_rr = 0; m_known = 1;
    end else if (video_on) begin
      m_addr = disp_addr; m_we = 0; m_known = 1;
    end else if (mw >= 0) begin
      m_addr  = wr_addr[mw*AW +: AW];
      m_wdata = wr_data[mw*DW +: DW];
      m_we = 1; m_known = 1;
      m_rr = (mw + 1) % N;
    end else begin
      m_we = 0; m_known = 0;
    end
    m_prev = cond_now();
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int w;
      logic [N-1:0] eg;
      w  = winner();
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", wr_gnt, eg);
      chk("we", mem_we, m_we);
      if (m_known) chk("addr", mem_addr, m_addr);
      if (m_we) chk("wdata", mem_wdata, m_wdata);
      chk("rvalid", disp_rvalid, m_vp[1]);
      chk("rdata", disp_rdata, m_vp[1] ? m_rd : '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_writers();
    for (int i = 0; i < int'(N); i++) begin
      wr_addr[i*AW +: AW] = AW'(32'h1000 + i);
      wr_data[i*DW +: DW] = DW'(i + 5);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] orig;
    logic [N-1:0]  got [$];
    logic [N-1:0]  rr_exp [6];
    bit            pend;
    logic [AW-1:0] pend_addr;
    int            last;

    for (int i = 0; i < 2**AW; i++) begin
      v = DW'($urandom);
      ram[i] = v; gold[i] = v;
    end
    ram[15'h0123] = 4'hA; gold[15'h0123] = 4'hA;

    rst = 1; video_on = 0; pixel_x = 12'd650; disp_addr = '0; wr_req = 4'b1111;
    set_writers();

    // reset held 3 cycles with all writers requesting
    tick();
    chk_en = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", wr_gnt, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rvalid", disp_rvalid, 0);
      tick();
    end
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_gnt != '0) break;
      tick();
    end
    chk("first_gnt", wr_gnt, 4'b0001);
    tick();

    // round-robin 0,1,3,0,1,3 with registered write one cycle later
    rst = 1; wr_req = 4'b1011;
    tick();
    rst = 0;
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    pend = 0; pend_addr = '0;
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      @(negedge clk);
      if (pend) begin
        chk("rr_we", mem_we, 1);
        chk("rr_addr", mem_addr, pend_addr);
      end
      pend = (wr_gnt != '0);
      if (pend) begin
        got.push_back(wr_gnt);
        pend_addr = AW'(32'h1000 + $clog2(wr_gnt));
      end
      tick();
    end
    for (int i = 0; i < 6; i++)
      chk("rr_seq", (i < got.size()) ? got[i] : '0, rr_exp[i]);

    // display priority
    video_on = 1; disp_addr = 15'h0123; wr_req = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("disp_gnt", wr_gnt, 0);
      if (c >= 1) chk("disp_we", mem_we, 0);
      if (c < 2)  chk("disp_rvalid_lo", disp_rvalid, 0);
      if (c >= 2) begin
        chk("disp_rvalid_hi", disp_rvalid, 1);
        chk("disp_rdata", disp_rdata, 4'hA);
      end
      tick();
    end

    // guard window at end of line
    video_on = 0; wr_req = 4'b1111; last = -1;
    for (int px = 790; px < 800; px++) begin
      pixel_x = 12'(px);
      @(negedge clk);
      if (wr_gnt != '0) last = px;
      tick();
    end
    chk("guard_last", last, 795);
    video_on = 1; pixel_x = 12'd0;
    @(negedge clk);
    chk("guard_we", mem_we, 0);
    tick();

    // reset in the would-be grant cycle discards the write and clears rr
    video_on = 0; pixel_x = 12'd650; wr_req = '0;
    tick();
    wr_addr[0 +: AW] = 15'h7777;
    orig = ram[15'h7777];
    wr_data[0 +: DW] = ~orig;
    wr_req = 4'b0001;
    tick();
    rst = 1;
    @(negedge clk);
    chk("mr_gnt", wr_gnt, 0);
    tick();
    rst = 0; wr_req = '0;
    @(negedge clk);
    chk("mr_we", mem_we, 0);
    tick(); tick();
    chk("mr_ram", ram[15'h7777], orig);
    wr_req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_gnt != '0) break;
      tick();
    end
    chk("mr_rr0", wr_gnt, 4'b0001);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) video_on = ~video_on;
      pixel_x = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(780, 799))
                                             : 12'($urandom_range(0, 799));
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(0, 3) == 0) wr_req[i] = ~wr_req[i];
      wr_addr   = (N*AW)'({$urandom, $urandom});
      wr_data   = (N*DW)'($urandom);
      disp_addr = AW'($urandom);
      tick();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
